ram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that drives the write and read ports of the team's dual-port RAM block (both RAM clocks tied to i_Clk).
- Generates RAM addresses and tracks occupancy.
- Hides the RAM's 1-cycle registered read latency behind a 2-entry prefetch buffer, so the user side is first-word-fall-through with valid/enable handshaking at full throughput.

---
 rtl/ram_fifo_ctrl_if.sv | 55 +++++
 rtl/ram_fifo_ctrl.sv | 127 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// User-side and RAM-side bus of the ram_fifo_ctrl FIFO controller.
// o_Overflow/o_Underflow exist only when RAM_FIFO_ERR_FLAGS_EN is defined.
interface ram_fifo_ctrl_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 256
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic             i_Wr_DV;
    logic [WIDTH-1:0] i_Wr_Data;
    logic             o_Full;
    logic             o_AF;
    logic             i_Rd_En;
    logic             o_Rd_DV;
    logic [WIDTH-1:0] o_Rd_Data;
    logic             o_Empty;
    logic             o_AE;
    logic [CW-1:0]    o_Count;
    logic [AW-1:0]    o_Ram_Wr_Addr;
    logic             o_Ram_Wr_DV;
    logic [WIDTH-1:0] o_Ram_Wr_Data;
    logic [AW-1:0]    o_Ram_Rd_Addr;
    logic             o_Ram_Rd_En;
    logic             i_Ram_Rd_DV;
    logic [WIDTH-1:0] i_Ram_Rd_Data;
`ifdef RAM_FIFO_ERR_FLAGS_EN
    logic             o_Overflow;
    logic             o_Underflow;

    modport slave (
        input  i_Wr_DV, i_Wr_Data, i_Rd_En, i_Ram_Rd_DV, i_Ram_Rd_Data,
        output o_Full, o_AF, o_Rd_DV, o_Rd_Data, o_Empty, o_AE, o_Count,
        output o_Ram_Wr_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_Addr, o_Ram_Rd_En,
        output o_Overflow, o_Underflow
    );
    modport master (
        output i_Wr_DV, i_Wr_Data, i_Rd_En, i_Ram_Rd_DV, i_Ram_Rd_Data,
        input  o_Full, o_AF, o_Rd_DV, o_Rd_Data, o_Empty, o_AE, o_Count,
        input  o_Ram_Wr_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_Addr, o_Ram_Rd_En,
        input  o_Overflow, o_Underflow
    );
`else
    modport slave (
        input  i_Wr_DV, i_Wr_Data, i_Rd_En, i_Ram_Rd_DV, i_Ram_Rd_Data,
        output o_Full, o_AF, o_Rd_DV, o_Rd_Data, o_Empty, o_AE, o_Count,
        output o_Ram_Wr_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_Addr, o_Ram_Rd_En
    );
    modport master (
        output i_Wr_DV, i_Wr_Data, i_Rd_En, i_Ram_Rd_DV, i_Ram_Rd_Data,
        input  o_Full, o_AF, o_Rd_DV, o_Rd_Data, o_Empty, o_AE, o_Count,
        input  o_Ram_Wr_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_Addr, o_Ram_Rd_En
    );
`endif
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller over a dual-port RAM with 1-cycle read latency, using a 2-entry prefetch buffer.
// Optional sticky o_Overflow/o_Underflow ports when RAM_FIFO_ERR_FLAGS_EN is defined.
module ram_fifo_ctrl #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4
) (
    input logic            i_Clk,
    input logic            i_Rst_L,
    ram_fifo_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_LEVEL);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    ram_cnt, ram_cnt_n, count, count_n;
    logic             in_flight;
    logic             head_v, head_v_n, skid_v, skid_v_n;
    logic [WIDTH-1:0] head_d, head_d_n, skid_d, skid_d_n;
    logic             full_q, af_q, empty_q, ae_q;
    logic             push, pop, ret, issue;
    logic [1:0]       occ;

    // Handshake qualification and RAM read issue decision
    always_comb begin
        push  = bus.i_Wr_DV & ~full_q;
        pop   = head_v & bus.i_Rd_En;
        ret   = bus.i_Ram_Rd_DV & in_flight;
        occ   = 2'(head_v) + 2'(skid_v) + 2'(in_flight) - 2'(pop);
        issue = (ram_cnt != '0) && (occ < 2'd2);
        ram_cnt_n = ram_cnt + CW'(push) - CW'(issue);
        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    // Prefetch buffer: pop shifts the skid entry up, then a returning word fills the first free slot
    always_comb begin
        head_v_n = head_v;
        head_d_n = head_d;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        if (pop) begin
            head_v_n = skid_v;
            head_d_n = skid_d;
            skid_v_n = 1'b0;
        end
        if (ret) begin
            if (!head_v_n) begin
                head_v_n = 1'b1;
                head_d_n = bus.i_Ram_Rd_Data;
            end else begin
                skid_v_n = 1'b1;
                skid_d_n = bus.i_Ram_Rd_Data;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            count     <= '0;
            in_flight <= 1'b0;
            head_v    <= 1'b0;
            head_d    <= '0;
            skid_v    <= 1'b0;
            skid_d    <= '0;
            full_q    <= 1'b0;
            af_q      <= (AF_LVL == '0);
            empty_q   <= 1'b1;
            ae_q      <= 1'b1;
        end else begin
            if (push)  wr_ptr <= wr_ptr + AW'(1);
            if (issue) rd_ptr <= rd_ptr + AW'(1);
            ram_cnt   <= ram_cnt_n;
            count     <= count_n;
            in_flight <= issue;
            head_v    <= head_v_n;
            head_d    <= head_d_n;
            skid_v    <= skid_v_n;
            skid_d    <= skid_d_n;
            // Flags track the post-edge count so they always agree with o_Count
            full_q    <= (count_n == FULL_LVL);
            af_q      <= (count_n >= AF_LVL);
            empty_q   <= (count_n == '0);
            ae_q      <= (count_n <= AE_LVL);
        end
    end

`ifdef RAM_FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (bus.i_Wr_DV & full_q);
            udf_q <= udf_q | (bus.i_Rd_En & ~head_v);
        end
    end

    assign bus.o_Overflow  = ovf_q;
    assign bus.o_Underflow = udf_q;
`endif

    assign bus.o_Full        = full_q;
    assign bus.o_AF          = af_q;
    assign bus.o_Empty       = empty_q;
    assign bus.o_AE          = ae_q;
    assign bus.o_Count       = count;
    assign bus.o_Rd_DV       = head_v;
    assign bus.o_Rd_Data     = head_d;
    assign bus.o_Ram_Wr_DV   = push;
    assign bus.o_Ram_Wr_Addr = wr_ptr;
    assign bus.o_Ram_Wr_Data = bus.i_Wr_Data;
    assign bus.o_Ram_Rd_En   = issue;
    assign bus.o_Ram_Rd_Addr = rd_ptr;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl (DEPTH=8) with a behavioural RAM and a queue-based reference model.
// Checks o_Overflow/o_Underflow too when RAM_FIFO_ERR_FLAGS_EN is defined.
module tb_ram_fifo_ctrl;
    localparam int unsigned W   = 16;
    localparam int unsigned D   = 8;
    localparam int unsigned AFL = 6;
    localparam int unsigned AEL = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();

    ram_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    // Behavioural dual-port RAM, registered read
    logic [W-1:0] mem [D];
    logic         ram_dv = 1'b0;
    logic [W-1:0] ram_q  = '0;
    always @(posedge clk) begin
        if (bus.o_Ram_Wr_DV) mem[bus.o_Ram_Wr_Addr] <= bus.o_Ram_Wr_Data;
        ram_dv <= bus.o_Ram_Rd_En;
        if (bus.o_Ram_Rd_En) ram_q <= mem[bus.o_Ram_Rd_Addr];
    end
    assign bus.i_Ram_Rd_DV   = ram_dv;
    assign bus.i_Ram_Rd_Data = ram_q;

    // Model: FIFO contents with the edge after which each word may sit at the head
    typedef struct {
        logic [W-1:0] d;
        int           rdy;
    } ent_t;
    ent_t mq[$];
    int   edge_n = 0;
    int   m_wptr = 0;
    bit   m_ovf  = 1'b0;
    bit   m_udf  = 1'b0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic bit m_dv();
        return (mq.size() > 0) && (mq[0].rdy <= edge_n);
    endfunction

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // One clock: drive inputs, advance the model across the edge, settle 1ns
    task automatic cyc(input bit wr, input logic [W-1:0] d, input bit rd, input bit rst);
        bit push, pop, ovf, udf;
        bus.i_Wr_DV   = wr;
        bus.i_Wr_Data = d;
        bus.i_Rd_En   = rd;
        rst_n         = ~rst;
        push = wr && (mq.size() < D);
        pop  = rd && m_dv();
        ovf  = wr && (mq.size() == D);
        udf  = rd && !m_dv();
        @(posedge clk);
        edge_n++;
        if (rst) begin
            mq.delete();
            m_wptr = 0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{d, edge_n + 2});
                m_wptr = (m_wptr + 1) % D;
            end
            m_ovf = m_ovf | ovf;
            m_udf = m_udf | udf;
        end
        #1;
    endtask

    task automatic pop_one(input string nm, input logic [W-1:0] req);
        int t = 0;
        while (!bus.o_Rd_DV && t < 20) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            t++;
        end
        if (!bus.o_Rd_DV) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: o_Rd_DV still 0 after %0d cycles", nm, t);
        end else begin
            cmp(nm, 32'(bus.o_Rd_Data), 32'(req));
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Per-cycle comparison of every meaningful output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("count", 32'(bus.o_Count), 32'(mq.size()));
            cmp("full",  32'(bus.o_Full),  32'(mq.size() == D));
            cmp("af",    32'(bus.o_AF),    32'(mq.size() >= AFL));
            cmp("empty", 32'(bus.o_Empty), 32'(mq.size() == 0));
            cmp("ae",    32'(bus.o_AE),    32'(mq.size() <= AEL));
            cmp("rd_dv", 32'(bus.o_Rd_DV), 32'(m_dv()));
            if (m_dv()) cmp("rd_data", 32'(bus.o_Rd_Data), 32'(mq[0].d));
            cmp("ram_wr_dv", 32'(bus.o_Ram_Wr_DV), 32'(bus.i_Wr_DV && (mq.size() < D)));
            if (bus.i_Wr_DV && (mq.size() < D)) begin
                cmp("ram_wr_addr", 32'(bus.o_Ram_Wr_Addr), 32'(m_wptr));
                cmp("ram_wr_data", 32'(bus.o_Ram_Wr_Data), 32'(bus.i_Wr_Data));
            end
`ifdef RAM_FIFO_ERR_FLAGS_EN
            cmp("overflow",  32'(bus.o_Overflow),  32'(m_ovf));
            cmp("underflow", 32'(bus.o_Underflow), 32'(m_udf));
`endif
        end
    end

    initial begin
        logic [W-1:0] got[$];
        int bubbles;
        bit primed;

        bus.i_Wr_DV = 1'b0; bus.i_Wr_Data = '0; bus.i_Rd_En = 1'b0;

        // Reset occupies edges 1-2
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b1);
        cmp("rst_rd_dv", 32'(bus.o_Rd_DV), 32'd0);
        cmp("rst_rd_data", 32'(bus.o_Rd_Data), 32'd0);
        cmp("rst_empty", 32'(bus.o_Empty), 32'd1);
        cmp("rst_ae", 32'(bus.o_AE), 32'd1);
        cmp("rst_full", 32'(bus.o_Full), 32'd0);
        cmp("rst_af", 32'(bus.o_AF), 32'd0);
        cmp("rst_count", 32'(bus.o_Count), 32'd0);

        // Push at edge 10, head valid after edge 12
        repeat (7) cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0001, 1'b0, 1'b0);
        cmp("lat_edge10", 32'(edge_n), 32'd10);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cmp("lat_n1_dv", 32'(bus.o_Rd_DV), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cmp("lat_n2_dv", 32'(bus.o_Rd_DV), 32'd1);
        cmp("lat_n2_data", 32'(bus.o_Rd_Data), 32'h0001);
        cmp("lat_n2_count", 32'(bus.o_Count), 32'd1);
        cmp("lat_n2_empty", 32'(bus.o_Empty), 32'd0);
        cmp("lat_n2_ae", 32'(bus.o_AE), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cmp("lat_pop_empty", 32'(bus.o_Empty), 32'd1);

        // Fill to full, drop a 9th push, drain in order
        for (int k = 0; k < 8; k++) cyc(1'b1, 16'(16'h10 + k), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cmp("fill_full", 32'(bus.o_Full), 32'd1);
        cmp("fill_count", 32'(bus.o_Count), 32'd8);
        cyc(1'b1, 16'h00EE, 1'b0, 1'b0);
        cmp("drop_count", 32'(bus.o_Count), 32'd8);
        for (int k = 0; k < 8; k++) pop_one("fill_order", 16'(16'h10 + k));
        cyc(1'b0, '0, 1'b0, 1'b0);
        cmp("drained_empty", 32'(bus.o_Empty), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Full with push and pop together: pop wins, push dropped, next push accepted
        for (int k = 0; k < 8; k++) cyc(1'b1, 16'(16'h20 + k), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 16'h00AA, 1'b1, 1'b0);
        cmp("fullpp_count", 32'(bus.o_Count), 32'd7);
        cyc(1'b1, 16'h00BB, 1'b0, 1'b0);
        cmp("fullpp_next_count", 32'(bus.o_Count), 32'd8);
        for (int k = 1; k < 8; k++) pop_one("fullpp_order", 16'(16'h20 + k));
        pop_one("fullpp_bb", 16'h00BB);

`ifdef RAM_FIFO_ERR_FLAGS_EN
        cmp("lit_overflow", 32'(bus.o_Overflow), 32'd1);
        cmp("lit_underflow", 32'(bus.o_Underflow), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cmp("lit_overflow_sticky", 32'(bus.o_Overflow), 32'd1);
`endif

        // Streaming 3*DEPTH words with rd_en held high
        bubbles = 0;
        primed  = 1'b0;
        for (int i = 0; i < 3 * D; i++) begin
            if (bus.o_Rd_DV) begin
                got.push_back(bus.o_Rd_Data);
                primed = 1'b1;
            end else if (primed) begin
                bubbles++;
            end
            cyc(1'b1, 16'(16'h100 + i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 10 && got.size() < 3 * D; i++) begin
            if (bus.o_Rd_DV) got.push_back(bus.o_Rd_Data);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        cmp("stream_bubbles", 32'(bubbles), 32'd0);
        cmp("stream_words", 32'(got.size()), 32'(3 * D));
        for (int k = 0; k < got.size(); k++) cmp("stream_data", 32'(got[k]), 32'(16'h100 + k));

        // Reset while a RAM read is in flight: returning word must be discarded
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0055, 1'b0, 1'b0);
        cmp("midrst_rd_en", 32'(bus.o_Ram_Rd_En), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cmp("midrst_ram_dv", 32'(bus.i_Ram_Rd_DV), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cmp("midrst_rd_dv", 32'(bus.o_Rd_DV), 32'd0);
        cmp("midrst_count", 32'(bus.o_Count), 32'd0);
`ifdef RAM_FIFO_ERR_FLAGS_EN
        cmp("midrst_overflow", 32'(bus.o_Overflow), 32'd0);
        cmp("midrst_underflow", 32'(bus.o_Underflow), 32'd0);
`endif
        cyc(1'b0, '0, 1'b0, 1'b0);
        cmp("midrst_rd_dv2", 32'(bus.o_Rd_DV), 32'd0);

        // Recovery after reset
        cyc(1'b1, 16'h0077, 1'b0, 1'b0);
        pop_one("recover", 16'h0077);
        cyc(1'b0, '0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
